// File: rtl/lookup_bit_rule_writer_pkg.sv
// rtl/lookup_bit_rule_writer_pkg.sv - shared set-interface constants and writer FSM encoding
// Purpose: definitions shared by the rule writer and the bit-vector lookup table.
// Ports: none (package).
package lookup_bit_rule_writer_pkg;

  // Set command layout: {op, subkey[7:0], rule[7:0]}
  localparam int SET_W         = 17;
  localparam int SET_OP_BIT    = 16;
  localparam int SET_SUBKEY_HI = 15;
  localparam int SET_SUBKEY_LO = 8;
  localparam int SET_RULE_HI   = 7;
  localparam int SET_RULE_LO   = 0;
  localparam int KEY_W         = SET_SUBKEY_HI - SET_SUBKEY_LO + 1;
  localparam int RULE_W        = SET_RULE_HI - SET_RULE_LO + 1;

  localparam logic SET_OP_ADD = 1'b1;
  localparam logic SET_OP_DEL = 1'b0;

  // The table needs this many cycles of read-modify-write per set
  localparam int SET_GAP_MIN = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } writer_state_t;

  // Next subkey in ascending order matching key under mask: forcing the care
  // bits to 1 makes the +1 carry ripple through them onto the free bits only.
  function automatic logic [KEY_W-1:0] next_subkey(input logic [KEY_W-1:0] cur,
                                                   input logic [KEY_W-1:0] key,
                                                   input logic [KEY_W-1:0] mask);
    logic [KEY_W:0] sum;
    sum = {1'b0, cur | mask} + {{KEY_W{1'b0}}, 1'b1};
    return (sum[KEY_W-1:0] & ~mask) | (key & mask);
  endfunction

endpackage

// File: rtl/lookup_bit_rule_writer.sv
// rtl/lookup_bit_rule_writer.sv - expands one ternary rule command into paced table set commands
// Purpose: accepts {op, key, mask, rule}; emits one set pulse per subkey matching
//   key under mask, ascending, SET_GAP cycles apart, then pulses done.
// Ports:
//   clk        in   clock
//   reset      in   synchronous active-low reset
//   cmd_valid  in   command present          cmd_ready out  idle, can accept
//   cmd_op     in   1=add 0=delete           cmd_key   in   subkey value
//   cmd_mask   in   1=care bit               cmd_rule  in   rule number
//   set_valid  out  one-cycle set pulse      set       out  {op, subkey, rule}
//   busy       out  expansion in progress    done      out  one-cycle completion pulse
//   set_count  out  sets issued for current/last command
module lookup_bit_rule_writer
  import lookup_bit_rule_writer_pkg::*;
#(
  parameter int SET_GAP = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [KEY_W-1:0]  cmd_key,
  input  logic [KEY_W-1:0]  cmd_mask,
  input  logic [RULE_W-1:0] cmd_rule,
  output logic              set_valid,
  output logic [SET_W-1:0]  set,
  output logic              busy,
  output logic              done,
  output logic [KEY_W:0]    set_count
);

  localparam int GAP_W = $clog2(SET_GAP + 1);

  if (SET_GAP < SET_GAP_MIN) begin : g_gap_check
    $error("lookup_bit_rule_writer: SET_GAP below table read-modify-write time");
  end

  writer_state_t     r_state, w_state;
  logic              r_op, w_op;
  logic [KEY_W-1:0]  r_key, w_key;
  logic [KEY_W-1:0]  r_mask, w_mask;
  logic [RULE_W-1:0] r_rule, w_rule;
  logic [KEY_W-1:0]  r_cur, w_cur;
  logic [GAP_W-1:0]  r_gap, w_gap;
  logic              r_set_valid, w_set_valid;
  logic [SET_W-1:0]  r_set, w_set;
  logic              r_cmd_ready, w_cmd_ready;
  logic              r_done, w_done;
  logic [KEY_W:0]    r_set_count, w_set_count;

  logic [KEY_W-1:0]  w_nxt_key;
  logic              w_last;

  assign w_nxt_key = next_subkey(r_cur, r_key, r_mask);
  // Last subkey once every don't-care bit has reached 1
  assign w_last    = ((r_cur & ~r_mask) == ~r_mask);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_op        <= 1'b0;
      r_key       <= '0;
      r_mask      <= '0;
      r_rule      <= '0;
      r_cur       <= '0;
      r_gap       <= '0;
      r_set_valid <= 1'b0;
      r_set       <= '0;
      r_cmd_ready <= 1'b1;
      r_done      <= 1'b0;
      r_set_count <= '0;
    end else begin
      r_state     <= w_state;
      r_op        <= w_op;
      r_key       <= w_key;
      r_mask      <= w_mask;
      r_rule      <= w_rule;
      r_cur       <= w_cur;
      r_gap       <= w_gap;
      r_set_valid <= w_set_valid;
      r_set       <= w_set;
      r_cmd_ready <= w_cmd_ready;
      r_done      <= w_done;
      r_set_count <= w_set_count;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_op        = r_op;
    w_key       = r_key;
    w_mask      = r_mask;
    w_rule      = r_rule;
    w_cur       = r_cur;
    w_gap       = r_gap;
    w_set_valid = 1'b0;
    w_set       = r_set;
    w_cmd_ready = r_cmd_ready;
    w_done      = 1'b0;
    w_set_count = r_set_count;

    case (r_state)
      ST_IDLE: begin
        if (cmd_valid && r_cmd_ready) begin
          w_op        = cmd_op;
          w_key       = cmd_key;
          w_mask      = cmd_mask;
          w_rule      = cmd_rule;
          w_cur       = cmd_key & cmd_mask;
          w_set_valid = 1'b1;
          w_set       = {cmd_op, cmd_key & cmd_mask, cmd_rule};
          w_set_count = {{KEY_W{1'b0}}, 1'b1};
          w_cmd_ready = 1'b0;
          w_state     = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        w_gap   = GAP_W'(SET_GAP - 1);
        w_state = ST_GAP;
      end

      ST_GAP: begin
        if (r_gap == GAP_W'(1)) begin
          w_gap = '0;
          if (w_last) begin
            w_done      = 1'b1;
            w_cmd_ready = 1'b1;
            w_state     = ST_IDLE;
          end else begin
            w_cur       = w_nxt_key;
            w_set_valid = 1'b1;
            w_set       = {r_op, w_nxt_key, r_rule};
            w_set_count = r_set_count + 1'b1;
            w_state     = ST_ISSUE;
          end
        end else begin
          w_gap = r_gap - 1'b1;
        end
      end

      default: begin
        w_cmd_ready = 1'b1;
        w_state     = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = r_cmd_ready;
  assign busy      = ~r_cmd_ready;
  assign set_valid = r_set_valid;
  assign set       = r_set;
  assign done      = r_done;
  assign set_count = r_set_count;

endmodule
